ctrl_pipeline: RTL and testbench

Carries the decoded control bundle from the ID stage through the ID/EX, EX/MEM and MEM/WB pipeline registers of the 5-stage RISC-V core. It is the consumer of the opcode decoder's control outputs. It detects load-use hazards, issues the IF/ID stall, inserts bubbles on stall or flush, and generates EX-stage operand forwarding selects. It sits between the decoder/register-file read in ID and the datapath muxes in EX, MEM and WB.

---
 rtl/ctrl_pipeline.sv | 184 ++++++++++++++++++
 tb/tb_ctrl_pipeline.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline: carries decoded control bundles through ID/EX, EX/MEM and
// MEM/WB, detects load-use hazards, raises the IF/ID stall, inserts bubbles
// on stall or flush, and produces EX-stage operand forwarding selects.
module ctrl_pipeline (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic       id_RegWrite,
  input  logic       id_ImmType,
  input  logic       id_PCToRegSrc,
  input  logic       id_RDSrc,
  input  logic       id_MemRead,
  input  logic       id_MemWrite,
  input  logic       id_MemToReg,
  input  logic       id_ALUSrc,
  input  logic [2:0] id_ALUOp,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] id_rd,
  input  logic       ex_flush,
  input  logic       freeze,
  output logic       stall,
  output logic       ex_ImmType,
  output logic       ex_PCToRegSrc,
  output logic       ex_RDSrc,
  output logic       ex_ALUSrc,
  output logic [2:0] ex_ALUOp,
  output logic [4:0] ex_rs1,
  output logic [4:0] ex_rs2,
  output logic       mem_MemRead,
  output logic       mem_MemWrite,
  output logic       wb_RegWrite,
  output logic       wb_MemToReg,
  output logic [4:0] wb_rd,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       imm_type;
    logic       pc_to_reg_src;
    logic       rd_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic [2:0] alu_op;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } idex_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic [4:0] rd;
  } exmem_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic [4:0] rd;
  } memwb_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_BUBBLE,
    ACT_ADVANCE
  } stage_act_e;

  idex_t      idex_q,  idex_next;
  exmem_t     exmem_q, exmem_next;
  memwb_t     memwb_q, memwb_next;
  idex_t      id_bundle;
  stage_act_e act;
  logic       lu;

  function automatic fwd_sel_e fwd_sel(input logic [4:0] rs,
                                       input logic       mem_rw,
                                       input logic [4:0] mem_rd,
                                       input logic       wb_rw,
                                       input logic [4:0] wb_rd_in);
    if (mem_rw && (mem_rd != 5'd0) && (mem_rd == rs))
      return FWD_MEM;
    else if (wb_rw && (wb_rd_in != 5'd0) && (wb_rd_in == rs))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

  // Pack the decoder outputs into one ID bundle.
  always_comb begin
    id_bundle               = '0;
    id_bundle.valid         = id_valid;
    id_bundle.reg_write     = id_RegWrite;
    id_bundle.imm_type      = id_ImmType;
    id_bundle.pc_to_reg_src = id_PCToRegSrc;
    id_bundle.rd_src        = id_RDSrc;
    id_bundle.mem_read      = id_MemRead;
    id_bundle.mem_write     = id_MemWrite;
    id_bundle.mem_to_reg    = id_MemToReg;
    id_bundle.alu_src       = id_ALUSrc;
    id_bundle.alu_op        = id_ALUOp;
    id_bundle.rs1           = id_rs1;
    id_bundle.rs2           = id_rs2;
    id_bundle.rd            = id_rd;
  end

  // Hazard detection, stall, and the per-edge stage action (freeze > flush > lu).
  always_comb begin
    lu    = id_valid && idex_q.mem_read && (idex_q.rd != 5'd0) &&
            ((idex_q.rd == id_rs1) || (idex_q.rd == id_rs2));
    stall = freeze | (lu & ~ex_flush);
    if (freeze)
      act = ACT_HOLD;
    else if (ex_flush || lu)
      act = ACT_BUBBLE;
    else
      act = ACT_ADVANCE;
  end

  // Next-state values for each stage register.
  always_comb begin
    idex_next = '0;
    if (act == ACT_ADVANCE && id_valid)
      idex_next = id_bundle;
    // Gating by valid is a no-op on bubbles (all fields already zero).
    exmem_next            = '0;
    exmem_next.reg_write  = idex_q.reg_write  & idex_q.valid;
    exmem_next.mem_read   = idex_q.mem_read   & idex_q.valid;
    exmem_next.mem_write  = idex_q.mem_write  & idex_q.valid;
    exmem_next.mem_to_reg = idex_q.mem_to_reg & idex_q.valid;
    exmem_next.rd         = idex_q.rd;
    memwb_next            = '0;
    memwb_next.reg_write  = exmem_q.reg_write;
    memwb_next.mem_to_reg = exmem_q.mem_to_reg;
    memwb_next.rd         = exmem_q.rd;
  end

  // Stage registers: reset to bubble, hold on freeze, otherwise load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else if (act != ACT_HOLD) begin
      idex_q  <= idex_next;
      exmem_q <= exmem_next;
      memwb_q <= memwb_next;
    end
  end

  // EX operand forwarding selects; EX/MEM takes precedence over MEM/WB.
  always_comb begin
    fwd_a = fwd_sel(idex_q.rs1, exmem_q.reg_write, exmem_q.rd,
                    memwb_q.reg_write, memwb_q.rd);
    fwd_b = fwd_sel(idex_q.rs2, exmem_q.reg_write, exmem_q.rd,
                    memwb_q.reg_write, memwb_q.rd);
  end

  assign ex_ImmType    = idex_q.imm_type;
  assign ex_PCToRegSrc = idex_q.pc_to_reg_src;
  assign ex_RDSrc      = idex_q.rd_src;
  assign ex_ALUSrc     = idex_q.alu_src;
  assign ex_ALUOp      = idex_q.alu_op;
  assign ex_rs1        = idex_q.rs1;
  assign ex_rs2        = idex_q.rs2;
  assign mem_MemRead   = exmem_q.mem_read;
  assign mem_MemWrite  = exmem_q.mem_write;
  assign wb_RegWrite   = memwb_q.reg_write;
  assign wb_MemToReg   = memwb_q.mem_to_reg;
  assign wb_rd         = memwb_q.rd;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Scoreboard bench for ctrl_pipeline: stimulus pushes expected outputs from an
// instruction-level pipeline model; a monitor pops and compares each cycle.
module tb_ctrl_pipeline;

  typedef struct packed {
    logic       valid, rw, imm, pcs, rds, mr, mw, m2r, as;
    logic [2:0] op;
    logic [4:0] rs1, rs2, rd;
  } ins_t;

  typedef struct packed {
    logic        stall;
    logic [1:0]  fa, fb;
    logic [16:0] ex;
    logic [1:0]  mem;
    logic [6:0]  wb;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, id_valid, id_RegWrite, id_ImmType, id_PCToRegSrc, id_RDSrc;
  logic id_MemRead, id_MemWrite, id_MemToReg, id_ALUSrc;
  logic [2:0] id_ALUOp;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic ex_flush, freeze, stall;
  logic ex_ImmType, ex_PCToRegSrc, ex_RDSrc, ex_ALUSrc;
  logic [2:0] ex_ALUOp;
  logic [4:0] ex_rs1, ex_rs2;
  logic mem_MemRead, mem_MemWrite, wb_RegWrite, wb_MemToReg;
  logic [4:0] wb_rd;
  logic [1:0] fwd_a, fwd_b;

  int checks = 0;
  int failures = 0;
  exp_t sb[$];
  bit   stim_done = 0;

  // Model state: the instruction occupying each stage.
  ins_t m_ex, m_mem, m_wb;
  bit   last_stall;

  always #5 clk = ~clk;

  ctrl_pipeline dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_RegWrite(id_RegWrite), .id_ImmType(id_ImmType),
    .id_PCToRegSrc(id_PCToRegSrc), .id_RDSrc(id_RDSrc),
    .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
    .id_MemToReg(id_MemToReg), .id_ALUSrc(id_ALUSrc), .id_ALUOp(id_ALUOp),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .ex_flush(ex_flush), .freeze(freeze), .stall(stall),
    .ex_ImmType(ex_ImmType), .ex_PCToRegSrc(ex_PCToRegSrc),
    .ex_RDSrc(ex_RDSrc), .ex_ALUSrc(ex_ALUSrc), .ex_ALUOp(ex_ALUOp),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
    .wb_RegWrite(wb_RegWrite), .wb_MemToReg(wb_MemToReg), .wb_rd(wb_rd),
    .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  function automatic ins_t nop();
    ins_t i = '0;
    return i;
  endfunction

  function automatic ins_t rtype(input logic [4:0] rd, rs1, rs2);
    ins_t i = '0;
    i.valid = 1; i.rw = 1; i.as = 1; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2;
    return i;
  endfunction

  function automatic ins_t load(input logic [4:0] rd, rs1);
    ins_t i = '0;
    i.valid = 1; i.rw = 1; i.mr = 1; i.m2r = 1; i.as = 1; i.imm = 1;
    i.op = 3'b000; i.rd = rd; i.rs1 = rs1;
    return i;
  endfunction

  function automatic ins_t rand_ins();
    ins_t i;
    i = '0;
    i.valid = ($urandom_range(0, 7) != 0);
    i.mr    = ($urandom_range(0, 2) == 0);
    i.m2r   = i.mr;
    i.rw    = i.mr | $urandom_range(0, 1);
    i.mw    = ~i.mr & ($urandom_range(0, 4) == 0);
    i.imm   = $urandom_range(0, 1);
    i.pcs   = $urandom_range(0, 1);
    i.rds   = $urandom_range(0, 1);
    i.as    = $urandom_range(0, 1);
    i.op    = 3'($urandom_range(0, 7));
    i.rs1   = 5'($urandom_range(0, 4));
    i.rs2   = 5'($urandom_range(0, 4));
    i.rd    = 5'($urandom_range(0, 4));
    return i;
  endfunction

  // Forward from the youngest older instruction that writes a nonzero rd.
  function automatic logic [1:0] exp_fwd(input logic [4:0] r);
    if (r != 0 && m_mem.valid && m_mem.rw && m_mem.rd == r) return 2'b10;
    if (r != 0 && m_wb.valid && m_wb.rw && m_wb.rd == r) return 2'b01;
    return 2'b00;
  endfunction

  task automatic cycle(input ins_t i, input bit fl, input bit fr, input bit rn);
    exp_t e;
    bit   hazard;
    id_valid = i.valid; id_RegWrite = i.rw; id_ImmType = i.imm;
    id_PCToRegSrc = i.pcs; id_RDSrc = i.rds; id_MemRead = i.mr;
    id_MemWrite = i.mw; id_MemToReg = i.m2r; id_ALUSrc = i.as;
    id_ALUOp = i.op; id_rs1 = i.rs1; id_rs2 = i.rs2; id_rd = i.rd;
    ex_flush = fl; freeze = fr; rst_n = rn;
    hazard = i.valid && m_ex.valid && m_ex.mr && m_ex.rd != 0 &&
             (m_ex.rd == i.rs1 || m_ex.rd == i.rs2);
    e.stall = fr || (hazard && !fl);
    e.fa    = exp_fwd(m_ex.rs1);
    e.fb    = exp_fwd(m_ex.rs2);
    e.ex    = {m_ex.imm, m_ex.pcs, m_ex.rds, m_ex.as, m_ex.op, m_ex.rs1, m_ex.rs2};
    e.mem   = {m_mem.mr, m_mem.mw};
    e.wb    = {m_wb.rw, m_wb.m2r, m_wb.rd};
    sb.push_back(e);
    last_stall = e.stall;
    @(posedge clk);
    if (!rn) begin
      m_ex = nop(); m_mem = nop(); m_wb = nop();
    end else if (!fr) begin
      m_wb  = m_mem;
      m_mem = m_ex;
      m_ex  = (fl || hazard || !i.valid) ? nop() : i;
    end
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: the DUT presents a full output set every cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("stall", 32'(stall), 32'(e.stall));
        chk("fwd_a", 32'(fwd_a), 32'(e.fa));
        chk("fwd_b", 32'(fwd_b), 32'(e.fb));
        chk("ex_bundle", 32'({ex_ImmType, ex_PCToRegSrc, ex_RDSrc, ex_ALUSrc,
                              ex_ALUOp, ex_rs1, ex_rs2}), 32'(e.ex));
        chk("mem_bundle", 32'({mem_MemRead, mem_MemWrite}), 32'(e.mem));
        chk("wb_bundle", 32'({wb_RegWrite, wb_MemToReg, wb_rd}), 32'(e.wb));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ins_t cur;
    bit   fl, fr;
    int   frz_left;
    ins_t rt;
    rt = rtype(5'd3, 5'd1, 5'd2);
    // Unchecked power-on edge establishes a known state.
    rst_n = 0; id_valid = 0; id_RegWrite = 0; id_ImmType = 0; id_PCToRegSrc = 0;
    id_RDSrc = 0; id_MemRead = 0; id_MemWrite = 0; id_MemToReg = 0; id_ALUSrc = 0;
    id_ALUOp = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; ex_flush = 0; freeze = 0;
    m_ex = nop(); m_mem = nop(); m_wb = nop();
    @(posedge clk); #1;

    // Reset held with a valid R-type bundle on the inputs.
    cycle(rt, 0, 0, 0);
    cycle(rt, 0, 0, 0);

    // EX/MEM forwarding on both operands.
    cycle(rtype(5'd3, 5'd1, 5'd2), 0, 0, 1);
    cycle(rtype(5'd4, 5'd3, 5'd3), 0, 0, 1);
    cycle(nop(), 0, 0, 1);
    cycle(nop(), 0, 0, 1);
    // MEM/WB forwarding on A only.
    cycle(rtype(5'd3, 5'd1, 5'd2), 0, 0, 1);
    cycle(rtype(5'd9, 5'd1, 5'd2), 0, 0, 1);
    cycle(rtype(5'd5, 5'd3, 5'd0), 0, 0, 1);
    repeat (3) cycle(nop(), 0, 0, 1);

    // Load-use: the dependent instruction is re-presented while stalled.
    cycle(load(5'd5, 5'd2), 0, 0, 1);
    cycle(rtype(5'd6, 5'd5, 5'd1), 0, 0, 1);
    cycle(rtype(5'd6, 5'd5, 5'd1), 0, 0, 1);
    repeat (3) cycle(nop(), 0, 0, 1);

    // x0 destination load never stalls or forwards.
    cycle(load(5'd0, 5'd2), 0, 0, 1);
    cycle(rtype(5'd7, 5'd0, 5'd0), 0, 0, 1);
    repeat (3) cycle(nop(), 0, 0, 1);

    // Flush in the same cycle as a load-use hazard.
    cycle(load(5'd5, 5'd2), 0, 0, 1);
    cycle(rtype(5'd6, 5'd5, 5'd1), 1, 0, 1);
    repeat (3) cycle(nop(), 0, 0, 1);

    // Freeze for three cycles mid-stream.
    cycle(rtype(5'd1, 5'd2, 5'd3), 0, 0, 1);
    cycle(load(5'd2, 5'd1), 0, 0, 1);
    cycle(rtype(5'd3, 5'd4, 5'd4), 0, 0, 1);
    repeat (3) cycle(rtype(5'd4, 5'd1, 5'd2), 0, 1, 1);
    cycle(rtype(5'd4, 5'd1, 5'd2), 0, 0, 1);
    repeat (3) cycle(nop(), 0, 0, 1);

    // Randomized traffic with held stall/flush semantics and freeze bursts.
    cur = rand_ins(); fl = 0; fr = 0; frz_left = 0;
    for (int n = 0; n < 2000; n++) begin
      if (!last_stall) cur = rand_ins();
      if (frz_left > 0) frz_left--;
      else if ($urandom_range(0, 15) == 0) frz_left = $urandom_range(1, 4);
      fr = (frz_left > 0);
      if (!fr || !fl) fl = ($urandom_range(0, 9) == 0);
      cycle(cur, fl, fr, ($urandom_range(0, 49) != 0));
    end

    @(negedge clk);
    for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clk);
    chk("scoreboard_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
